// File: rtl/mult_div_iter.sv
// Iterative RV32M multiply/divide unit.
// One 64-bit {hi, lo} register pair is shared by a 32-step shift-add
// multiplier and a 32-step restoring divider. Operands are reduced to
// magnitudes at accept, and the result sign is restored in one FIXUP cycle.
module mult_div_iter #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_a,
  input  logic [XLEN-1:0] req_b,
  input  logic            flush,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_data,
  output logic            busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIXUP,
    S_DONE
  } state_t;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [2:0]        r_funct3;
  logic              r_signA;
  logic              r_signB;
  logic [XLEN-1:0]   r_hi;
  logic [XLEN-1:0]   r_lo;
  logic [XLEN-1:0]   r_opnd;
  logic [XLEN-1:0]   r_respData;

  logic              w_accept;
  logic              w_isDiv;
  logic              w_aSigned;
  logic              w_bSigned;
  logic              w_signA;
  logic              w_signB;
  logic [XLEN-1:0]   w_absA;
  logic [XLEN-1:0]   w_absB;
  logic              w_divZero;
  logic              w_overflow;
  logic [XLEN-1:0]   w_specialData;

  logic [XLEN:0]     w_mulSum;
  logic [XLEN:0]     w_remShift;
  logic [XLEN:0]     w_diff;
  logic              w_qBit;

  logic [2*XLEN-1:0] w_prod;
  logic              w_prodNeg;
  logic [2*XLEN-1:0] w_prodFix;
  logic [XLEN-1:0]   w_quoFix;
  logic [XLEN-1:0]   w_remFix;
  logic [XLEN-1:0]   w_fixData;

  // Request decode: which operands are signed, their magnitudes, and the
  // divide corner cases that skip the iteration entirely.
  always_comb begin
    w_accept   = req_valid && (r_state == S_IDLE);
    w_isDiv    = req_funct3[2];
    w_aSigned  = w_isDiv ? ~req_funct3[0] : (req_funct3[1:0] != 2'b11);
    w_bSigned  = w_isDiv ? ~req_funct3[0] : ~req_funct3[1];
    w_signA    = w_aSigned & req_a[XLEN-1];
    w_signB    = w_bSigned & req_b[XLEN-1];
    w_absA     = w_signA ? (~req_a + 1'b1) : req_a;
    w_absB     = w_signB ? (~req_b + 1'b1) : req_b;
    w_divZero  = w_isDiv && (req_b == '0);
    w_overflow = w_isDiv && !req_funct3[0] && (req_a == MIN_NEG) && (req_b == '1);
    if (w_divZero) begin
      w_specialData = req_funct3[1] ? req_a : '1;
    end else begin
      w_specialData = req_funct3[1] ? '0 : MIN_NEG;
    end
  end

  // One iteration step: conditional add for multiply, trial subtract for divide.
  always_comb begin
    w_mulSum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : {(XLEN+1){1'b0}});
    w_remShift = {r_hi, r_lo[XLEN-1]};
    w_diff     = w_remShift - {1'b0, r_opnd};
    w_qBit     = ~w_diff[XLEN];
  end

  // Result sign restoration and output word selection.
  always_comb begin
    w_prod    = {r_hi, r_lo};
    w_prodNeg = (r_funct3[1:0] == 2'b10) ? r_signA : (r_signA ^ r_signB);
    w_prodFix = w_prodNeg ? (~w_prod + 1'b1) : w_prod;
    w_quoFix  = (r_signA ^ r_signB) ? (~r_lo + 1'b1) : r_lo;
    w_remFix  = r_signA ? (~r_hi + 1'b1) : r_hi;
    case (r_funct3)
      3'b000:                 w_fixData = w_prodFix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: w_fixData = w_prodFix[2*XLEN-1:XLEN];
      3'b100, 3'b101:         w_fixData = w_quoFix;
      default:                w_fixData = w_remFix;
    endcase
  end

  // Control FSM and datapath registers; flush overrides every other transition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_funct3   <= '0;
      r_signA    <= 1'b0;
      r_signB    <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_opnd     <= '0;
      r_respData <= '0;
    end else if (flush) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_funct3 <= req_funct3;
            r_signA  <= w_signA;
            r_signB  <= w_signB;
            r_cnt    <= '0;
            r_hi     <= '0;
            if (w_isDiv) begin
              r_lo   <= w_absA;
              r_opnd <= w_absB;
            end else begin
              r_lo   <= w_absB;
              r_opnd <= w_absA;
            end
            if (w_divZero || w_overflow) begin
              r_respData <= w_specialData;
              r_state    <= S_DONE;
            end else begin
              r_state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (r_funct3[2]) begin
            r_hi <= w_qBit ? w_diff[XLEN-1:0] : w_remShift[XLEN-1:0];
            r_lo <= {r_lo[XLEN-2:0], w_qBit};
          end else begin
            r_hi <= w_mulSum[XLEN:1];
            r_lo <= {w_mulSum[0], r_lo[XLEN-1:1]};
          end
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CNT_W'(XLEN-1)) begin
            r_state <= S_FIXUP;
          end
        end
        S_FIXUP: begin
          r_respData <= w_fixData;
          r_state    <= S_DONE;
        end
        S_DONE: begin
          if (resp_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Handshake outputs come straight from the state register.
  always_comb begin
    req_ready  = (r_state == S_IDLE);
    resp_valid = (r_state == S_DONE);
    busy       = (r_state != S_IDLE);
    resp_data  = r_respData;
  end

endmodule

// File: tb/tb_mult_div_iter.sv
// Directed self-checking bench for mult_div_iter.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_mult_div_iter;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_funct3;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        flush;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic        busy;

  int checks;
  int errors;
  int lat;
  int readyHigh;
  int count;

  mult_div_iter #(.XLEN(32), .CNT_W(6)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_funct3 (req_funct3),
    .req_a      (req_a),
    .req_b      (req_b),
    .flush      (flush),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .busy       (busy)
  );

  // Free-running 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Present one request at a falling edge; it is accepted at the next rising edge.
  task automatic applyStimulus(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    req_funct3 = f3;
    req_a      = a;
    req_b      = b;
    req_valid  = 1'b1;
    checkOutput("accept_ready", {31'b0, req_ready}, 32'd1);
    @(negedge clk);
    req_valid  = 1'b0;
  endtask

  // lat = index k of the first rising edge T+k at which resp_valid is sampled high.
  task automatic waitResp(output int latency, output int readySeen);
    latency   = 1;
    readySeen = 0;
    while (resp_valid !== 1'b1 && latency < 100) begin
      if (req_ready) readySeen++;
      @(negedge clk);
      latency++;
    end
  endtask

  task automatic consume();
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  task automatic runOp(input string tag, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] expData, input int expLat);
    int l;
    int r;
    applyStimulus(f3, a, b);
    waitResp(l, r);
    checkOutput({tag, "_lat"}, 32'(l), 32'(expLat));
    checkOutput({tag, "_data"}, resp_data, expData);
    checkOutput({tag, "_busyReady"}, 32'(r), 32'd0);
    consume();
    checkOutput({tag, "_idle"}, {30'b0, resp_valid, req_ready}, 32'd1);
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_funct3 = 3'b000;
    req_a      = '0;
    req_b      = '0;
    flush      = 1'b0;
    resp_ready = 1'b0;

    #12;
    checkOutput("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    checkOutput("rst_resp_data", resp_data, 32'd0);
    checkOutput("rst_busy", {31'b0, busy}, 32'd0);
    checkOutput("rst_req_ready", {31'b0, req_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] multiply");
    runOp("mul",    3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 34);
    runOp("mulh",   3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 34);
    runOp("mulhu",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34);
    runOp("mulhsu", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34);
    checkOutput("data_retained", resp_data, 32'hFFFFFFFF);

    $display("[TB] divide");
    runOp("div",  3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 34);
    runOp("rem",  3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 34);
    runOp("divu", 3'b101, 32'd100,      32'd7, 32'd14,       34);
    runOp("remu", 3'b111, 32'd100,      32'd7, 32'd2,        34);

    $display("[TB] special cases");
    runOp("divu_zero", 3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1);
    runOp("rem_zero",  3'b110, 32'd5,        32'd0,        32'd5,        1);
    runOp("div_ovf",   3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    runOp("rem_ovf",   3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1);

    $display("[TB] backpressure and back-to-back");
    applyStimulus(3'b101, 32'd100, 32'd7);
    waitResp(lat, readyHigh);
    checkOutput("bp_data", resp_data, 32'd14);
    count = 0;
    repeat (5) begin
      @(negedge clk);
      if (resp_valid !== 1'b1 || resp_data !== 32'd14) count++;
    end
    checkOutput("bp_stable", 32'(count), 32'd0);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    checkOutput("bp_idle", {30'b0, resp_valid, req_ready}, 32'd1);
    applyStimulus(3'b000, 32'd3, 32'd5);
    checkOutput("b2b_busy", {31'b0, busy}, 32'd1);
    waitResp(lat, readyHigh);
    checkOutput("b2b_lat", 32'(lat), 32'd34);
    checkOutput("b2b_data", resp_data, 32'd15);
    consume();

    $display("[TB] flush");
    applyStimulus(3'b000, 32'd123, 32'd456);
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checkOutput("flush_state", {29'b0, busy, resp_valid, req_ready}, 32'd1);
    count = 0;
    repeat (40) begin
      @(negedge clk);
      if (resp_valid !== 1'b0) count++;
    end
    checkOutput("flush_no_resp", 32'(count), 32'd0);
    runOp("mul_after_flush", 3'b000, 32'd3, 32'd4, 32'd12, 34);

    req_funct3 = 3'b000;
    req_a      = 32'd9;
    req_b      = 32'd9;
    req_valid  = 1'b1;
    flush      = 1'b1;
    @(negedge clk);
    req_valid  = 1'b0;
    flush      = 1'b0;
    checkOutput("flush_idle_drop", {31'b0, busy}, 32'd0);

    applyStimulus(3'b101, 32'd5, 32'd0);
    checkOutput("flush_done_pre", {31'b0, resp_valid}, 32'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checkOutput("flush_done_post", {30'b0, resp_valid, req_ready}, 32'd1);

    $display("[TB] reset mid-operation");
    applyStimulus(3'b001, 32'h12345678, 32'h9ABCDEF0);
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("arst_outputs", {29'b0, busy, resp_valid, req_ready}, 32'd1);
    checkOutput("arst_data", resp_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("arst_release_ready", {31'b0, req_ready}, 32'd1);
    count = 0;
    repeat (40) begin
      @(negedge clk);
      if (resp_valid !== 1'b0) count++;
    end
    checkOutput("arst_no_resp", 32'(count), 32'd0);
    runOp("remu_after_reset", 3'b111, 32'd100, 32'd7, 32'd2, 34);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
